pwm_tick_generator: RTL
=======================

Name: pwm_tick_generator

Overview:
- Downstream consumer of clock_divider's slow_clk.
- Synchronises slow_clk into the clk domain and turns each rising edge into a one-cycle tick.
- Runs a WIDTH-bit PWM counter on those ticks and drives the LED PWM output.
- Duty values arrive from the UART command path over a valid/ready handshake and are double-buffered, so a new duty takes effect only at a period boundary.

Parameters:
- WIDTH, 8: counter and duty width; PWM period is 2^WIDTH ticks.
- SYNC_STAGES, 2: synchroniser flops on slow_clk; minimum 2.

Ports:
- clk  input  1  system clock, 25 MHz.
- rst  input  1  asynchronous, active-high reset.
- slow_clk  input  1  divided clock from clock_divider; sampled as data, never used as a clock.
- enable  input  1  run/stop for the PWM.
- duty_in  input  WIDTH  requested duty (high ticks per period).
- duty_valid  input  1  duty_in valid.
- duty_ready  output  1  block can accept a duty; equals ~pending.
- pwm_out  output  1  registered PWM output to the LED.
- period_start  output  1  one-cycle pulse when the counter wraps to 0.
- duty_active  output  WIDTH  duty currently in effect.

Behaviour:
- Reset (async, immediate): sync chain, edge flop, cnt, duty_active, pending, pwm_out and period_start all 0; duty_ready=1.
- Sync and tick: s[0..SYNC_STAGES-1] shift slow_clk; flop d holds the previous s[last]; tick = s[last] & ~d.
  - slow_clk first sampled high at clk edge k -> tick high between edges k+SYNC_STAGES-1 and k+SYNC_STAGES; cnt updates at edge k+SYNC_STAGES.
  - Exactly one tick per slow_clk rising edge, independent of slow_clk frequency.
  - slow_clk high at reset release counts as one rising edge.
- Counter: on tick with enable=1, cnt <= cnt+1, wrapping from 2^WIDTH-1 to 0.
  - Wrap = tick while cnt == 2^WIDTH-1.
  - period_start <= 1 for the one cycle after the wrap edge; 0 otherwise.
- PWM: pwm_out <= enable & (cnt < duty_active), evaluated on every clk edge (one clk of latency after cnt/duty_active).
  - duty 0 -> pwm_out never high.
  - duty 2^WIDTH-1 -> high for 2^WIDTH-1 of 2^WIDTH ticks.
- Handshake: transfer when duty_valid & duty_ready at a clk edge.
  - pend_val <= duty_in; pending <= 1; duty_ready low from the next cycle.
  - duty_valid while duty_ready=0 is ignored; no queuing beyond one entry.
- Apply (enable=1): at a wrap edge with pending=1, duty_active <= pend_val and pending <= 0; duty_ready returns to 1 the next cycle.
- Simultaneous accept and wrap on the same edge: the value goes to pend_val and applies at the following wrap. It is never applied on the same edge, since pending was 0 before that edge.
- enable=0:
  - cnt is forced to 0 on every edge; ticks are ignored; period_start stays 0; pwm_out is 0 after one edge.
  - If pending=1, duty_active <= pend_val on the next edge without waiting for a wrap.
  - The handshake still operates.
- enable rising: cnt starts at 0; first tick takes cnt to 1. No period_start until the first wrap.
- Reset mid-period: all state cleared at once and any pending duty is discarded; operation resumes from cnt=0 after release.

Test Plan:
- Common setup: WIDTH=4, SYNC_STAGES=2, 40 ns clk, slow_clk toggling every 4 clk (one tick per 8 clk).
- Reset: rst=1 for 100 ns with slow_clk toggling -> pwm_out=0, period_start=0, duty_active=0, duty_ready=1; after release with duty 0, pwm_out stays 0 for 32 ticks.
- Steady duty: enable=1, write duty 4 -> duty_ready=0 until the next wrap; then duty_active=4, pwm_out high for exactly 4 ticks (32 clk) of every 16-tick period (128 clk), period_start once per 128 clk.
- Extremes: duty 0 -> pwm_out never high over 3 periods; duty 15 -> high 15 of 16 ticks, low only while cnt=15 (+1 clk latency).
- Back-to-back writes: write 3, then present 9 while duty_ready=0 -> 9 ignored; at wrap duty_active=3, duty_ready=1 next cycle; re-present 9 -> applied at the following wrap.
- Coincident events: duty_valid=1 with value 7 on the exact wrap edge -> duty_active unchanged for that period, becomes 7 one wrap (16 ticks) later.
- Stop and abort: enable=0 at cnt=6 with 5 pending -> cnt=0, pwm_out=0 after 1 clk, duty_active=5 next clk. Separately, rst pulsed at cnt=9 -> outputs cleared without a clk edge, pending discarded.

Source files
------------

// File: rtl/pwm_tick_generator.sv
// PWM generator clocked by ticks derived from an asynchronous slow_clk.
// Duty updates are double-buffered and take effect only at a period boundary.
module pwm_tick_generator #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             slow_clk,
  input  logic             enable,
  input  logic [WIDTH-1:0] duty_in,
  input  logic             duty_valid,
  output logic             duty_ready,
  output logic             pwm_out,
  output logic             period_start,
  output logic [WIDTH-1:0] duty_active
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   tick;
  logic [WIDTH-1:0]       cnt;
  logic [WIDTH-1:0]       pend_val;
  logic                   pending;
  logic                   wrap;
  logic                   accept;
  logic                   apply;

  // slow_clk is treated purely as data; edge_q starts at 0 so a level that is
  // already high when reset releases still produces one tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], slow_clk};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign tick = sync_q[SYNC_STAGES-1] & ~edge_q;
  assign wrap = enable & tick & (cnt == CNT_MAX);

  // Handshake: a duty transfers on any clk edge where duty_valid and
  // duty_ready are both high; duty_ready is low while one value is pending,
  // and duty_valid seen during that time is dropped, not queued.
  assign duty_ready = ~pending;
  assign accept     = duty_valid & ~pending;
  // When stopped there is no period to protect, so a pending duty lands at once.
  assign apply      = pending & (~enable | wrap);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!enable) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_start <= 1'b0;
      pwm_out      <= 1'b0;
    end else begin
      period_start <= wrap;
      pwm_out      <= enable & (cnt < duty_active);
    end
  end

  // accept needs pending=0 and apply needs pending=1, so they never coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending     <= 1'b0;
      pend_val    <= '0;
      duty_active <= '0;
    end else if (accept) begin
      pending  <= 1'b1;
      pend_val <= duty_in;
    end else if (apply) begin
      pending     <= 1'b0;
      duty_active <= pend_val;
    end
  end

endmodule
